// File: rtl/axi_stream_if.sv
// AXI-stream subset (tvalid/tready/tdata/tlast) carrying configuration beats to the fabric.
interface axi_stream_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/bitstream_loader.sv
// Configuration sequencer: pulses fabric cfg, re-frames buffered host bytes into an
// AXI-stream bitstream with per-CLB tlast, then waits for cfg_ready and holds run.
module bitstream_loader #(
    parameter int DATA_WIDTH     = 8,
    parameter int CLB_COUNT      = 4,
    parameter int WORDS_PER_CLB  = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  host_start,
    input  logic [DATA_WIDTH-1:0] host_data,
    input  logic                  host_strobe,
    output logic                  host_ready,
    output logic                  busy,
    output logic                  overflow,
    output logic                  timeout,
    output logic                  fab_cfg,
    axi_stream_if.master          cfg_bitstream,
    input  logic                  fab_cfg_ready,
    output logic                  fab_run
);
    localparam int TOTAL = CLB_COUNT * WORDS_PER_CLB;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int FW    = (WORDS_PER_CLB > 1) ? $clog2(WORDS_PER_CLB) : 1;

    localparam logic [CW-1:0] TOTAL_C        = CW'(TOTAL);
    localparam logic [CW-1:0] LAST_BEAT_C    = CW'(TOTAL - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST_C = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [FW-1:0] FRAME_LAST_C   = FW'(WORDS_PER_CLB - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CFG_PULSE = 3'd1,
        ST_STREAM    = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RUNNING   = 3'd4
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;

    logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [AW:0]           wr_ptr_r;
    logic [AW:0]           rd_ptr_r;
    logic [CW-1:0]         sent_r;
    logic [CW-1:0]         written_r;
    logic [TW-1:0]         wait_cnt_r;
    logic [FW-1:0]         frame_beat_r;
    logic                  overflow_r;
    logic                  timeout_r;

    logic                  fifo_empty_s;
    logic                  fifo_full_s;
    logic                  restart_s;
    logic                  loading_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  drop_s;
    logic                  wait_expire_s;
    logic                  host_ready_s;
    logic                  busy_s;
    logic                  fab_cfg_s;
    logic                  fab_run_s;
    logic                  tvalid_s;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign fifo_empty_s  = (wr_ptr_r == rd_ptr_r);
    assign fifo_full_s   = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                           (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign restart_s     = host_start && ((state_r == ST_IDLE) || (state_r == ST_RUNNING));
    assign loading_s     = (state_r == ST_CFG_PULSE) || (state_r == ST_STREAM);
    assign push_s        = host_strobe && host_ready_s;
    assign pop_s         = tvalid_s && cfg_bitstream.tready;
    assign drop_s        = host_strobe && !host_ready_s && loading_s;
    assign wait_expire_s = (state_r == ST_WAIT_DONE) && !fab_cfg_ready &&
                           (wait_cnt_r == TIMEOUT_LAST_C);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; host_start is only honoured outside a configuration.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (host_start) begin
                    state_nxt_s = ST_CFG_PULSE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CFG_PULSE: begin
                state_nxt_s = ST_STREAM;
            end
            ST_STREAM: begin
                if (pop_s && (sent_r == LAST_BEAT_C)) begin
                    state_nxt_s = ST_WAIT_DONE;
                end else begin
                    state_nxt_s = ST_STREAM;
                end
            end
            ST_WAIT_DONE: begin
                if (fab_cfg_ready) begin
                    state_nxt_s = ST_RUNNING;
                end else if (wait_expire_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_DONE;
                end
            end
            ST_RUNNING: begin
                if (host_start) begin
                    state_nxt_s = ST_CFG_PULSE;
                end else begin
                    state_nxt_s = ST_RUNNING;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from registered state and FIFO occupancy only.
    always_comb begin
        host_ready_s = 1'b0;
        busy_s       = 1'b0;
        fab_cfg_s    = 1'b0;
        fab_run_s    = 1'b0;
        tvalid_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            ST_CFG_PULSE: begin
                busy_s       = 1'b1;
                fab_cfg_s    = 1'b1;
                host_ready_s = !fifo_full_s && (written_r < TOTAL_C);
            end
            ST_STREAM: begin
                busy_s       = 1'b1;
                host_ready_s = !fifo_full_s && (written_r < TOTAL_C);
                tvalid_s     = !fifo_empty_s;
            end
            ST_WAIT_DONE: begin
                busy_s = 1'b1;
            end
            ST_RUNNING: begin
                fab_run_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // FIFO storage; cleared on reset so tdata never exposes stale contents.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= host_data;
        end else begin
            mem_r <= mem_r;
        end
    end

    // Pointers, beat counters, wait counter and sticky status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            sent_r       <= '0;
            written_r    <= '0;
            wait_cnt_r   <= '0;
            frame_beat_r <= '0;
            overflow_r   <= 1'b0;
            timeout_r    <= 1'b0;
        end else if (restart_s) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            sent_r       <= '0;
            written_r    <= '0;
            wait_cnt_r   <= '0;
            frame_beat_r <= '0;
            overflow_r   <= 1'b0;
            timeout_r    <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
                if (written_r != TOTAL_C) begin
                    written_r <= written_r + CW'(1);
                end
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
                if (sent_r != TOTAL_C) begin
                    sent_r <= sent_r + CW'(1);
                end
                if (frame_beat_r == FRAME_LAST_C) begin
                    frame_beat_r <= '0;
                end else begin
                    frame_beat_r <= frame_beat_r + FW'(1);
                end
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            if ((state_r == ST_WAIT_DONE) && !fab_cfg_ready) begin
                if (wait_expire_s) begin
                    timeout_r <= 1'b1;
                end else begin
                    wait_cnt_r <= wait_cnt_r + TW'(1);
                end
            end
        end
    end

    assign host_ready           = host_ready_s;
    assign busy                 = busy_s;
    assign overflow             = overflow_r;
    assign timeout              = timeout_r;
    assign fab_cfg              = fab_cfg_s;
    assign fab_run              = fab_run_s;
    assign cfg_bitstream.tvalid = tvalid_s;
    assign cfg_bitstream.tdata  = tvalid_s ? mem_r[rd_ptr_r[AW-1:0]] : '0;
    assign cfg_bitstream.tlast  = tvalid_s && (frame_beat_r == FRAME_LAST_C);

endmodule

// File: tb/tb_bitstream_loader.sv
// Directed bench for bitstream_loader: nominal load, backpressure, overflow,
// timeout, restart rules and mid-stream reset, with hand-computed expectations.
module tb_bitstream_loader;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          host_start;
    logic          host_strobe;
    logic [DW-1:0] host_data;
    logic          fab_cfg_ready;
    logic          host_ready;
    logic          busy;
    logic          overflow;
    logic          timeout;
    logic          fab_cfg;
    logic          fab_run;

    axi_stream_if #(.DATA_WIDTH(DW)) bs_if ();

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int cfg_pulses = 0;

    logic [7:0] got_data [$];
    logic       got_last [$];
    int         got_cyc  [$];
    logic [7:0] exp_data [$];

    bitstream_loader #(
        .DATA_WIDTH(DW), .CLB_COUNT(4), .WORDS_PER_CLB(4),
        .FIFO_DEPTH(4), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .host_start(host_start), .host_data(host_data),
        .host_strobe(host_strobe), .host_ready(host_ready), .busy(busy),
        .overflow(overflow), .timeout(timeout), .fab_cfg(fab_cfg),
        .cfg_bitstream(bs_if), .fab_cfg_ready(fab_cfg_ready), .fab_run(fab_run)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every beat that the next rising edge will accept, plus cfg pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bs_if.tvalid && bs_if.tready) begin
                got_data.push_back(bs_if.tdata);
                got_last.push_back(bs_if.tlast);
                got_cyc.push_back(cyc);
            end
            if (fab_cfg) cfg_pulses <= cfg_pulses + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cfg();
        host_start = 1'b1;
        step();
        host_start = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            int budget;
            budget = 0;
            while (!host_ready && budget < 100) begin
                step();
                budget++;
            end
            check_eq("send_rdy", host_ready, 1);
            host_strobe = 1'b1;
            host_data   = base + 8'(k);
            step();
            host_strobe = 1'b0;
        end
    endtask

    task automatic wait_beats(input int target);
        for (int t = 0; t < 300 && got_data.size() < target; t++) step();
        check_eq("beat_count", got_data.size(), target);
    endtask

    task automatic verify_beats(input int first, input string tag);
        logic [31:0] act;
        for (int i = 0; i < 16; i++) begin
            if (first + i < got_data.size()) act = {23'd0, got_last[first+i], got_data[first+i]};
            else act = 32'hFFFF_FFFF;
            check_eq($sformatf("%s[%0d]", tag, i), act, {23'd0, (i % 4 == 3), exp_data[i]});
        end
    endtask

    task automatic check_idle(input string pfx);
        check_eq({pfx, "_host_ready"}, host_ready, 0);
        check_eq({pfx, "_busy"}, busy, 0);
        check_eq({pfx, "_overflow"}, overflow, 0);
        check_eq({pfx, "_timeout"}, timeout, 0);
        check_eq({pfx, "_fab_cfg"}, fab_cfg, 0);
        check_eq({pfx, "_fab_run"}, fab_run, 0);
        check_eq({pfx, "_tvalid"}, bs_if.tvalid, 0);
        check_eq({pfx, "_tlast"}, bs_if.tlast, 0);
    endtask

    initial begin
        int base, pulses0, pushed, sent_n, k_last;
        logic seen_full, prev_stall;
        logic [8:0] prev_beat;

        rst_n = 1'b0; host_start = 1'b0; host_strobe = 1'b0; host_data = '0;
        fab_cfg_ready = 1'b0; bs_if.tready = 1'b0;
        step(); step();
        check_idle("rst");
        rst_n = 1'b1;
        step();

        // Nominal load: 0x00..0x0F, cfg_ready two cycles after the last beat.
        base = got_data.size(); pulses0 = cfg_pulses;
        bs_if.tready = 1'b1;
        start_cfg();
        check_eq("nom_cfg_pulse", fab_cfg, 1);
        check_eq("nom_busy", busy, 1);
        send_bytes(8'h00, 16);
        wait_beats(base + 16);
        check_eq("nom_wait_busy", busy, 1);
        check_eq("nom_wait_tvalid", bs_if.tvalid, 0);
        step();
        fab_cfg_ready = 1'b1;
        check_eq("nom_run_early", fab_run, 0);
        step();
        fab_cfg_ready = 1'b0;
        check_eq("nom_run", fab_run, 1);
        check_eq("nom_idle_busy", busy, 0);
        check_eq("nom_overflow", overflow, 0);
        check_eq("nom_cfg_count", cfg_pulses - pulses0, 1);
        exp_data.delete();
        for (int i = 0; i < 16; i++) exp_data.push_back(8'(i));
        verify_beats(base, "nom_beat");

        // Backpressure: random tready, host strobes whenever host_ready.
        base = got_data.size();
        start_cfg();
        pushed = 0; seen_full = 1'b0; prev_stall = 1'b0; prev_beat = '0;
        for (int t = 0; t < 600; t++) begin
            if (prev_stall)
                check_eq("bp_hold", {22'd0, bs_if.tvalid, bs_if.tlast, bs_if.tdata}, {22'd0, 1'b1, prev_beat});
            if (pushed - (got_data.size() - base) == 4) begin
                check_eq("bp_full_rdy", host_ready, 0);
                seen_full = 1'b1;
            end
            bs_if.tready = (t < 8) ? 1'b0 : 1'($urandom_range(1, 0));
            if (host_ready && pushed < 16) begin
                host_strobe = 1'b1;
                host_data   = 8'h20 + 8'(pushed);
                pushed++;
            end else begin
                host_strobe = 1'b0;
            end
            prev_stall = bs_if.tvalid && !bs_if.tready;
            prev_beat  = {bs_if.tlast, bs_if.tdata};
            step();
            if (got_data.size() >= base + 16) break;
        end
        host_strobe = 1'b0;
        bs_if.tready = 1'b1;
        check_eq("bp_count", got_data.size() - base, 16);
        check_eq("bp_full_seen", seen_full, 1);
        check_eq("bp_overflow", overflow, 0);
        exp_data.delete();
        for (int i = 0; i < 16; i++) exp_data.push_back(8'h20 + 8'(i));
        verify_beats(base, "bp_beat");
        fab_cfg_ready = 1'b1;
        step();
        fab_cfg_ready = 1'b0;
        check_eq("bp_run", fab_run, 1);

        // Overflow/excess: 20 strobes ignoring host_ready, tready low for the first 6.
        base = got_data.size();
        start_cfg();
        for (int i = 0; i < 20; i++) begin
            host_strobe  = 1'b1;
            host_data    = 8'h40 + 8'(i);
            bs_if.tready = (i >= 6);
            if (i == 4) check_eq("ov_full_rdy", host_ready, 0);
            if (i == 6) check_eq("ov_sticky", overflow, 1);
            step();
        end
        host_strobe = 1'b0;
        wait_beats(base + 16);
        exp_data.delete();
        for (int i = 0; i < 4; i++) exp_data.push_back(8'h40 + 8'(i));
        for (int i = 0; i < 12; i++) exp_data.push_back(8'h47 + 8'(i));
        verify_beats(base, "ov_beat");
        check_eq("ov_flag_end", overflow, 1);

        // Timeout: cfg_ready stays low after the last beat.
        k_last = (got_cyc.size() >= base + 16) ? got_cyc[base+15] : cyc;
        for (int t = 0; t < 200 && cyc < k_last + 64; t++) step();
        check_eq("to_pre_flag", timeout, 0);
        check_eq("to_pre_busy", busy, 1);
        step();
        check_eq("to_flag", timeout, 1);
        check_eq("to_idle", busy, 0);
        check_eq("to_run", fab_run, 0);
        check_eq("ov_exact", got_data.size() - base, 16);

        // Restart rules: start clears flags; mid-stream start ignored; RUNNING start restarts.
        base = got_data.size(); pulses0 = cfg_pulses;
        start_cfg();
        check_eq("rs_clear_to", timeout, 0);
        check_eq("rs_clear_ov", overflow, 0);
        send_bytes(8'h80, 5);
        host_start = 1'b1;
        step();
        host_start = 1'b0;
        check_eq("rs_ign_cfg", fab_cfg, 0);
        check_eq("rs_ign_busy", busy, 1);
        send_bytes(8'h85, 11);
        wait_beats(base + 16);
        exp_data.delete();
        for (int i = 0; i < 16; i++) exp_data.push_back(8'h80 + 8'(i));
        verify_beats(base, "rs_beat");
        check_eq("rs_cfg_count", cfg_pulses - pulses0, 1);
        fab_cfg_ready = 1'b1;
        step();
        fab_cfg_ready = 1'b0;
        check_eq("rs_run", fab_run, 1);
        host_start = 1'b1;
        step();
        host_start = 1'b0;
        check_eq("rs_run_drop", fab_run, 0);
        check_eq("rs_new_cfg", fab_cfg, 1);
        step();
        check_eq("rs_cfg_end", fab_cfg, 0);
        check_eq("rs_busy", busy, 1);

        // Reset after 6 beats, then a fresh load starts from its first byte.
        base = got_data.size(); sent_n = 0;
        for (int t = 0; t < 100; t++) begin
            if (host_ready && sent_n < 10) begin
                host_strobe = 1'b1;
                host_data   = 8'hA0 + 8'(sent_n);
                sent_n++;
            end else begin
                host_strobe = 1'b0;
            end
            step();
            if (got_data.size() >= base + 6) break;
        end
        host_strobe = 1'b0;
        rst_n = 1'b0;
        step();
        check_idle("mr");
        check_eq("mr_beats", got_data.size() - base, 6);
        rst_n = 1'b1;
        step();
        base = got_data.size();
        start_cfg();
        send_bytes(8'hC0, 16);
        wait_beats(base + 16);
        exp_data.delete();
        for (int i = 0; i < 16; i++) exp_data.push_back(8'hC0 + 8'(i));
        verify_beats(base, "mr_beat");
        fab_cfg_ready = 1'b1;
        step();
        fab_cfg_ready = 1'b0;
        check_eq("mr_run", fab_run, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
